// File: rtl/usbdev_aon_suspend_seq_pkg.sv
// Shared types for the AON suspend/wake sequencer.
//   wake_cause_e  : latched reason for the most recent wake.
//   seq_state_e   : sequencer FSM state, exported for debug.
//   timer_width() : phase timer width able to hold both phase timeouts.
package usbdev_aon_suspend_seq_pkg;

    typedef enum logic [2:0] {
        WakeNone      = 3'd0,
        WakeNotIdle   = 3'd1,
        WakeBusReset  = 3'd2,
        WakeSenseLost = 3'd3,
        WakeSw        = 3'd4
    } wake_cause_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArming  = 3'd1,
        StActive  = 3'd2,
        StWaking  = 3'd3,
        StRelease = 3'd4
    } seq_state_e;

    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/usbdev_aon_suspend_seq_if.sv
// Handshake and event signals between the sequencer and the AON wake detector.
//   suspend_req_aon    : sequencer -> detector, level suspend request.
//   wake_ack_aon       : sequencer -> detector, level wake acknowledge.
//   wake_detect_active : detector owns the pull-ups.
//   wake_req           : detector wake request (level).
//   bus_not_idle, bus_reset, sense_lost : detector event flags (levels).
// master = sequencer side, slave = detector side.
interface usbdev_aon_suspend_seq_if;

    logic suspend_req_aon;
    logic wake_ack_aon;
    logic wake_detect_active;
    logic wake_req;
    logic bus_not_idle;
    logic bus_reset;
    logic sense_lost;

    modport master (
        output suspend_req_aon,
        output wake_ack_aon,
        input  wake_detect_active,
        input  wake_req,
        input  bus_not_idle,
        input  bus_reset,
        input  sense_lost
    );

    modport slave (
        input  suspend_req_aon,
        input  wake_ack_aon,
        output wake_detect_active,
        output wake_req,
        output bus_not_idle,
        output bus_reset,
        output sense_lost
    );

endinterface

// File: rtl/usbdev_aon_suspend_seq_phase_timer.sv
// Phase timer: up-counter with synchronous clear and a terminal-count flag.
// Reused for both the ARMING and RELEASE phases; the caller selects the
// terminal value for the phase in progress.
//   clk_aon_i, rst_aon_ni : AON clock, async active-low reset.
//   clr_i                 : clear count to zero (wins over inc_i).
//   inc_i                 : advance count by one.
//   tc_val_i              : terminal value to compare against.
//   tc_o                  : count equals tc_val_i.
module usbdev_aon_suspend_seq_phase_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_aon_i,
    input  logic             rst_aon_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [Width-1:0] tc_val_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/usbdev_aon_suspend_seq.sv
// AON suspend/wake sequencer. Turns one-cycle software suspend/resume pulses
// into the level suspend_req/wake_ack handshake of the wake detector,
// supervises the ARMING and RELEASE phases with timeouts, latches a
// prioritised wake cause and counts completed wakes (saturating).
//   clk_aon_i, rst_aon_ni : AON clock, async active-low reset.
//   suspend_cmd_i         : pulse, request suspend entry (IDLE only).
//   resume_cmd_i          : pulse, acknowledge wake / software wake / abort arm.
//   clr_i                 : pulse, clear err_o, cause_o, wake_cnt_o.
//   det_io                : detector handshake and event flags.
//   wake_irq_o            : pulse on entry to WAKING.
//   cause_o               : latched wake cause (wake_cause_e).
//   wake_cnt_o            : saturating count of completed wakes.
//   err_o                 : sticky timeout / unexpected-drop error.
//   state_o               : current FSM state (seq_state_e).
module usbdev_aon_suspend_seq
    import usbdev_aon_suspend_seq_pkg::*;
#(
    parameter int unsigned ArmTimeout = 16,
    parameter int unsigned RelTimeout = 16,
    parameter int unsigned CntW       = 8
) (
    input  logic                     clk_aon_i,
    input  logic                     rst_aon_ni,
    input  logic                     suspend_cmd_i,
    input  logic                     resume_cmd_i,
    input  logic                     clr_i,
    usbdev_aon_suspend_seq_if.master det_io,
    output logic                     wake_irq_o,
    output logic [2:0]               cause_o,
    output logic [CntW-1:0]          wake_cnt_o,
    output logic                     err_o,
    output logic [2:0]               state_o
);

    localparam int unsigned TimerW = timer_width(ArmTimeout, RelTimeout);

    seq_state_e       state_q, state_d;
    wake_cause_e      cause_q, cause_d;
    wake_cause_e      hw_cause;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             suspend_req_q, wake_ack_q, irq_q;
    logic             timer_clr, timer_inc, timer_tc;
    logic [TimerW-1:0] timer_tc_val;

    // Detector event priority; a bare wake_req is treated as bus activity.
    always_comb begin
        if (det_io.sense_lost) begin
            hw_cause = WakeSenseLost;
        end else if (det_io.bus_reset) begin
            hw_cause = WakeBusReset;
        end else begin
            hw_cause = WakeNotIdle;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;

        // Clear first so any same-cycle set below overrides it.
        if (clr_i) begin
            err_d   = 1'b0;
            cause_d = WakeNone;
            cnt_d   = '0;
        end

        case (state_q)
            StIdle: begin
                if (suspend_cmd_i) begin
                    state_d = StArming;
                end
            end
            StArming: begin
                if (det_io.wake_detect_active) begin
                    state_d = StActive;
                end else if (resume_cmd_i) begin
                    state_d = StIdle;
                end else if (timer_tc) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StActive: begin
                if (det_io.wake_req) begin
                    state_d = StWaking;
                    cause_d = hw_cause;
                end else if (resume_cmd_i) begin
                    state_d = StRelease;
                    cause_d = WakeSw;
                end else if (!det_io.wake_detect_active) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StWaking: begin
                // No timeout: the IP may still be powering up.
                if (resume_cmd_i) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!det_io.wake_detect_active) begin
                    state_d = StIdle;
                    cnt_d   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
                end else if (timer_tc) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign timer_clr    = (state_d != state_q);
    assign timer_inc    = (state_q == StArming) || (state_q == StRelease);
    assign timer_tc_val = (state_q == StRelease) ? TimerW'(RelTimeout - 1)
                                                 : TimerW'(ArmTimeout - 1);

    usbdev_aon_suspend_seq_phase_timer #(
        .Width (TimerW)
    ) u_phase_timer (
        .clk_aon_i  (clk_aon_i),
        .rst_aon_ni (rst_aon_ni),
        .clr_i      (timer_clr),
        .inc_i      (timer_inc),
        .tc_val_i   (timer_tc_val),
        .tc_o       (timer_tc)
    );

    // Outputs are flopped decodes of the next state so they line up with state_q.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state_q       <= StIdle;
            cause_q       <= WakeNone;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            suspend_req_q <= 1'b0;
            wake_ack_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            suspend_req_q <= (state_d == StArming);
            wake_ack_q    <= (state_d == StRelease);
            irq_q         <= (state_d == StWaking) && (state_q != StWaking);
        end
    end

    assign det_io.suspend_req_aon = suspend_req_q;
    assign det_io.wake_ack_aon    = wake_ack_q;
    assign wake_irq_o             = irq_q;
    assign cause_o                = cause_q;
    assign wake_cnt_o             = cnt_q;
    assign err_o                  = err_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_usbdev_aon_suspend_seq.sv
// Directed bench for usbdev_aon_suspend_seq (CntW=2 so saturation is reachable).
module tb_usbdev_aon_suspend_seq;

    logic       clk;
    logic       rst_n;
    logic       suspend_cmd;
    logic       resume_cmd;
    logic       clr;
    logic       wake_irq;
    logic [2:0] cause;
    logic [1:0] wake_cnt;
    logic       err;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int hi;

    usbdev_aon_suspend_seq_if det_if ();

    usbdev_aon_suspend_seq #(
        .ArmTimeout (16),
        .RelTimeout (16),
        .CntW       (2)
    ) dut (
        .clk_aon_i     (clk),
        .rst_aon_ni    (rst_n),
        .suspend_cmd_i (suspend_cmd),
        .resume_cmd_i  (resume_cmd),
        .clr_i         (clr),
        .det_io        (det_if),
        .wake_irq_o    (wake_irq),
        .cause_o       (cause),
        .wake_cnt_o    (wake_cnt),
        .err_o         (err),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        suspend_cmd = 0; resume_cmd = 0; clr = 0;
        det_if.wake_detect_active = 0; det_if.wake_req = 0;
        det_if.bus_not_idle = 0; det_if.bus_reset = 0; det_if.sense_lost = 0;
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_sreq", det_if.suspend_req_aon, 0);
        chk("rst_ack", det_if.wake_ack_aon, 0);
        chk("rst_irq", wake_irq, 0);
        chk("rst_cause", cause, 0);
        chk("rst_cnt", wake_cnt, 0);
        chk("rst_err", err, 0);
        repeat (2) step();
        rst_n = 1;
        step();
        chk("post_rst_state", state, 0);

        // Normal cycle with bus reset cause
        suspend_cmd = 1; step(); suspend_cmd = 0;
        chk("norm_arming", state, 1);
        chk("norm_sreq_lat", det_if.suspend_req_aon, 1);
        step(); step();
        chk("norm_sreq_hold", det_if.suspend_req_aon, 1);
        det_if.wake_detect_active = 1; step();
        chk("norm_active", state, 2);
        chk("norm_sreq_drop", det_if.suspend_req_aon, 0);
        repeat (3) step();
        suspend_cmd = 1; step(); suspend_cmd = 0;
        chk("norm_susp_ignored", state, 2);
        det_if.bus_reset = 1; det_if.wake_req = 1; step();
        chk("norm_waking", state, 3);
        chk("norm_irq", wake_irq, 1);
        chk("norm_cause", cause, 2);
        det_if.bus_reset = 0; det_if.wake_req = 0; step();
        chk("norm_irq_once", wake_irq, 0);
        repeat (25) step();
        chk("norm_waking_no_to", state, 3);
        resume_cmd = 1; step(); resume_cmd = 0;
        chk("norm_release", state, 4);
        chk("norm_ack", det_if.wake_ack_aon, 1);
        step();
        chk("norm_ack_hold", det_if.wake_ack_aon, 1);
        det_if.wake_detect_active = 0; step();
        chk("norm_idle", state, 0);
        chk("norm_ack_drop", det_if.wake_ack_aon, 0);
        chk("norm_cnt", wake_cnt, 1);
        chk("norm_err", err, 0);

        resume_cmd = 1; step(); resume_cmd = 0;
        chk("idle_resume_ignored", state, 0);

        // Arm timeout: suspend_req high for exactly 16 cycles
        suspend_cmd = 1; step(); suspend_cmd = 0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (det_if.suspend_req_aon) hi++;
            step();
        end
        chk("arm_to_cycles", hi, 16);
        chk("arm_to_state", state, 0);
        chk("arm_to_err", err, 1);
        chk("arm_to_cnt_kept", wake_cnt, 1);
        clr = 1; step(); clr = 0;
        chk("clr_err", err, 0);
        chk("clr_cause", cause, 0);
        chk("clr_cnt", wake_cnt, 0);

        // Abort arming with resume
        suspend_cmd = 1; step(); suspend_cmd = 0;
        resume_cmd = 1; step(); resume_cmd = 0;
        chk("abort_state", state, 0);
        chk("abort_err", err, 0);

        // Software wake
        suspend_cmd = 1; step(); suspend_cmd = 0;
        det_if.wake_detect_active = 1; step();
        chk("sw_active", state, 2);
        resume_cmd = 1; step(); resume_cmd = 0;
        chk("sw_release", state, 4);
        chk("sw_cause", cause, 4);
        chk("sw_no_irq", wake_irq, 0);
        chk("sw_ack", det_if.wake_ack_aon, 1);
        det_if.wake_detect_active = 0; step();
        chk("sw_idle", state, 0);
        chk("sw_cnt", wake_cnt, 1);

        // Simultaneous wake_req + resume with sense_lost/not_idle flags
        suspend_cmd = 1; step(); suspend_cmd = 0;
        det_if.wake_detect_active = 1; step();
        det_if.wake_req = 1; resume_cmd = 1; det_if.sense_lost = 1; det_if.bus_not_idle = 1;
        step();
        det_if.wake_req = 0; resume_cmd = 0; det_if.sense_lost = 0; det_if.bus_not_idle = 0;
        chk("prio_waking", state, 3);
        chk("prio_cause", cause, 3);
        chk("prio_irq", wake_irq, 1);
        resume_cmd = 1; step(); resume_cmd = 0;
        det_if.wake_detect_active = 0; step();
        chk("prio_cnt", wake_cnt, 2);

        // Release timeout: ack high exactly 16 cycles, counter unchanged
        suspend_cmd = 1; step(); suspend_cmd = 0;
        det_if.wake_detect_active = 1; step();
        resume_cmd = 1; step(); resume_cmd = 0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (det_if.wake_ack_aon) hi++;
            step();
        end
        chk("rel_to_cycles", hi, 16);
        chk("rel_to_state", state, 0);
        chk("rel_to_err", err, 1);
        chk("rel_to_cnt_kept", wake_cnt, 2);
        det_if.wake_detect_active = 0;
        clr = 1; step(); clr = 0;
        chk("clr2_cnt", wake_cnt, 0);

        // Saturation over five wakes, bare wake_req -> not-idle cause
        for (int k = 1; k <= 5; k++) begin
            suspend_cmd = 1; step(); suspend_cmd = 0;
            det_if.wake_detect_active = 1; step();
            det_if.wake_req = 1; step(); det_if.wake_req = 0;
            chk("sat_cause", cause, 1);
            resume_cmd = 1; step(); resume_cmd = 0;
            det_if.wake_detect_active = 0; step();
            chk("sat_cnt", wake_cnt, (k > 3) ? 3 : k);
        end

        // Reset mid-RELEASE
        suspend_cmd = 1; step(); suspend_cmd = 0;
        det_if.wake_detect_active = 1; step();
        resume_cmd = 1; step(); resume_cmd = 0;
        chk("mid_rel_ack", det_if.wake_ack_aon, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_ack", det_if.wake_ack_aon, 0);
        chk("mid_rst_sreq", det_if.suspend_req_aon, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_cnt", wake_cnt, 0);
        chk("mid_rst_cause", cause, 0);
        chk("mid_rst_err", err, 0);
        det_if.wake_detect_active = 0;
        step();
        rst_n = 1;
        step();
        chk("mid_rst_after", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
